sync_fifo: RTL and testbench



---
 rtl/sync_fifo.sv | 102 ++++++++++
 tb/tb_sync_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock 16x8 FIFO with occupancy count, full/empty flags and registered read data.
// Optional sticky overflow/underflow outputs are enabled by defining FIFO_ERR_FLAGS_EN.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] d_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic [ADDR_WIDTH:0]   fifo_counter,
    output logic                  full,
    output logic                  empty
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  wr_fire, rd_fire;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);

    // Reset blocks the storage write too, so a write requested during reset never lands.
    assign wr_fire = reset & wr_en & ~full;
    assign rd_fire = reset & rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        if (!reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            dout_d   = '0;
        end else begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (rd_fire) begin
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
                dout_d   = mem_q[rd_ptr_q];
            end
            case ({wr_fire, rd_fire})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        dout_q   <= dout_d;
    end

    // Storage is never cleared; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_ptr_q] <= d_in;
    end

    assign d_out        = dout_q;
    assign fifo_counter = cnt_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q | (wr_en & full);
        unf_d = unf_q | (rd_en & empty);
        if (!reset) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        ovf_q <= ovf_d;
        unf_q <= unf_d;
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: queue-based reference model checked every cycle, directed scenarios
// with literal expectations, then randomized traffic with occasional resets.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] d_in;
    logic       wr_en, rd_en;
    logic [7:0] d_out;
    logic [4:0] fifo_counter;
    logic       full, empty;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow, underflow;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .d_in         (d_in),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .d_out        (d_out),
        .fifo_counter (fifo_counter),
        .full         (full),
        .empty        (empty)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    // Reference model: a plain queue of accepted bytes plus the last byte read out.
    logic [7:0] mq[$];
    logic [7:0] m_dout;
    logic       m_ovf, m_unf;
    bit         model_valid = 1'b0;

    always @(posedge clk) begin
        if (!reset) begin
            mq.delete();
            m_dout      = 8'h00;
            m_ovf       = 1'b0;
            m_unf       = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            bit wf, rf;
            if (wr_en && mq.size() == 16) m_ovf = 1'b1;
            if (rd_en && mq.size() == 0)  m_unf = 1'b1;
            wf = wr_en && (mq.size() < 16);
            rf = rd_en && (mq.size() > 0);
            if (rf) m_dout = mq.pop_front();
            if (wf) mq.push_back(d_in);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (model_valid) begin
            checks++;
            if (d_out !== m_dout || fifo_counter !== 5'(mq.size()) ||
                full !== (mq.size() == 16) || empty !== (mq.size() == 0)) begin
                failures++;
                $display("FAIL model_cmp: got dout=%0h cnt=%0d full=%0b empty=%0b expected dout=%0h cnt=%0d at %0t",
                         d_out, fifo_counter, full, empty, m_dout, mq.size(), $time);
            end
`ifdef FIFO_ERR_FLAGS_EN
            checks++;
            if (overflow !== m_ovf || underflow !== m_unf) begin
                failures++;
                $display("FAIL err_flags: got ovf=%0b unf=%0b expected ovf=%0b unf=%0b at %0t",
                         overflow, underflow, m_ovf, m_unf, $time);
            end
`endif
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr_en = w;
        rd_en = r;
        d_in  = d;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        d_in  = 8'h00;
        @(negedge clk);

        // Reset held two cycles with a write request pending
        cyc(1'b1, 1'b0, 8'hAA);
        cyc(1'b1, 1'b0, 8'hAA);
        check("rst_count", fifo_counter, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_dout", d_out, 8'h00);

        // Single write / read
        reset = 1'b1;
        cyc(1'b1, 1'b0, 8'hB1);
        check("wr1_count", fifo_counter, 1);
        check("wr1_empty", empty, 0);
        cyc(1'b0, 1'b1, 8'h00);
        check("rd1_dout", d_out, 8'hB1);
        check("rd1_count", fifo_counter, 0);
        check("rd1_empty", empty, 1);
        cyc(1'b0, 1'b1, 8'h00);
        check("rd_empty_hold", d_out, 8'hB1);
`ifdef FIFO_ERR_FLAGS_EN
        check("underflow_set", underflow, 1);
`endif

        // Fill, overfill, drain
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(i));
        check("fill_full", full, 1);
        check("fill_count", fifo_counter, 16);
        cyc(1'b1, 1'b0, 8'hFD);
        check("overfill_count", fifo_counter, 16);
`ifdef FIFO_ERR_FLAGS_EN
        check("overflow_set", overflow, 1);
`endif
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            check("drain_order", d_out, i);
        end
        check("drain_empty", empty, 1);

        // Wrap-around
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i));
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 8'h00);
        check("wrap_pre_dout", d_out, 8'h19);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i));
        check("wrap_full", full, 1);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 8'h00);
            check("wrap_order", d_out, 8'h20 + i);
        end

        // Simultaneous access at count 5, at empty, at full
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h40 + i));
        cyc(1'b1, 1'b1, 8'h50);
        check("both5_count", fifo_counter, 5);
        check("both5_dout", d_out, 8'h40);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h00);
        check("both5_last", d_out, 8'h50);
        cyc(1'b1, 1'b1, 8'h60);
        check("both_empty_count", fifo_counter, 1);
        check("both_empty_dout", d_out, 8'h50);
        cyc(1'b0, 1'b1, 8'h00);
        check("both_empty_data", d_out, 8'h60);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(8'h80 + i));
        cyc(1'b1, 1'b1, 8'h77);
        check("both_full_count", fifo_counter, 15);
        check("both_full_dout", d_out, 8'h80);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 8'h00);
        check("both_full_drop", d_out, 8'h8F);
        check("both_full_empty", empty, 1);

        // Mid-operation reset
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
        check("mid_pre_count", fifo_counter, 7);
        reset = 1'b0;
        cyc(1'b0, 1'b1, 8'h00);
        reset = 1'b1;
        check("mid_count", fifo_counter, 0);
        check("mid_empty", empty, 1);
        check("mid_dout", d_out, 8'h00);
        cyc(1'b1, 1'b0, 8'h99);
        cyc(1'b0, 1'b1, 8'h00);
        check("mid_new_data", d_out, 8'h99);
        check("mid_new_empty", empty, 1);

        // Randomized traffic with occasional resets; the model compare covers it
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias  = (i / 500) % 3;
            reset = ($urandom_range(0, 299) != 0);
            cyc(($urandom_range(0, 9) < 3 + 2 * bias) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) < 7 - 2 * bias) ? 1'b1 : 1'b0,
                8'($urandom));
        end
        reset = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
